// File: rtl/duck_sprite_fetch.sv
// Duck sprite fetch: bounding-box test, sprite ROM addressing and FLY/HIT/FALL animation FSM.
// Optional macro DUCK_SCALE2_EN doubles the on-screen box so each texel covers 2x2 pixels.
module duck_sprite_fetch #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int NUM_FRAMES = 6,
    parameter int FRAME_DIV  = 4,
    parameter int HIT_HOLD   = 30,
    parameter int ADDR_W     = 13
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              vs,
    input  logic [9:0]        duck_x,
    input  logic [9:0]        duck_y,
    input  logic              face_left,
    input  logic              shot_hit,
    input  logic              respawn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        palette_index,
    output logic              sprite_on,
    output logic [1:0]        anim_state
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
`ifdef DUCK_SCALE2_EN
    localparam int SHIFT = 1;
`else
    localparam int SHIFT = 0;
`endif
    localparam logic [10:0] BOX_W = 11'(SPR_W << SHIFT);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SHIFT);

    typedef enum logic [1:0] {
        ST_FLY  = 2'b00,
        ST_HIT  = 2'b01,
        ST_FALL = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic [FW-1:0]   frame_r, frame_s;
    logic [DW-1:0]   div_r, div_s;
    logic [HW-1:0]   hold_r, hold_s;
    logic            vs_d_r, tick_r;
    logic            v1_r, v2_r;

    logic [10:0]     draw_x_s, draw_y_s, box_x_s, box_y_s;
    logic [10:0]     dx_s, dy_s, dxs_s, dys_s;
    logic            in_box_s;
    logic [CW-1:0]   col_s;
    logic [ADDR_W-1:0] addr_s;

    // 11-bit arithmetic keeps a box clipped at the right/bottom edge from wrapping
    assign draw_x_s = {1'b0, DrawX};
    assign draw_y_s = {1'b0, DrawY};
    assign box_x_s  = {1'b0, duck_x};
    assign box_y_s  = {1'b0, duck_y};
    assign dx_s     = draw_x_s - box_x_s;
    assign dy_s     = draw_y_s - box_y_s;
    assign dxs_s    = dx_s >> SHIFT;
    assign dys_s    = dy_s >> SHIFT;
    assign in_box_s = (draw_x_s >= box_x_s) && (draw_x_s < (box_x_s + BOX_W)) &&
                      (draw_y_s >= box_y_s) && (draw_y_s < (box_y_s + BOX_H));
    assign col_s    = face_left ? (CW'(SPR_W - 1) - dxs_s[CW-1:0]) : dxs_s[CW-1:0];
    assign addr_s   = ADDR_W'({frame_r, dys_s[RW-1:0], col_s});

    assign anim_state = state_r;

    // Vsync falling-edge detector producing one tick per video frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_d_r <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            vs_d_r <= vs;
            tick_r <= vs_d_r & ~vs;
        end
    end

    // Animation state registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_FLY;
            frame_r <= '0;
            div_r   <= '0;
            hold_r  <= '0;
        end else begin
            state_r <= state_s;
            frame_r <= frame_s;
            div_r   <= div_s;
            hold_r  <= hold_s;
        end
    end

    // Animation next-state: pulses take priority over, and swallow, a coincident tick
    always_comb begin
        state_s = state_r;
        frame_s = frame_r;
        div_s   = div_r;
        hold_s  = hold_r;
        if (respawn) begin
            state_s = ST_FLY;
            frame_s = FW'(0);
            div_s   = '0;
        end else if (shot_hit && (state_r == ST_FLY)) begin
            state_s = ST_HIT;
            frame_s = FW'(3);
            hold_s  = '0;
        end else if (tick_r) begin
            case (state_r)
                ST_FLY: begin
                    if (div_r == DW'(FRAME_DIV - 1)) begin
                        div_s   = '0;
                        frame_s = (frame_r == FW'(2)) ? FW'(0) : frame_r + FW'(1);
                    end else begin
                        div_s   = div_r + DW'(1);
                    end
                end
                ST_HIT: begin
                    if (hold_r == HW'(HIT_HOLD - 1)) begin
                        state_s = ST_FALL;
                        frame_s = FW'(4);
                        div_s   = '0;
                    end else begin
                        hold_s  = hold_r + HW'(1);
                    end
                end
                ST_FALL: begin
                    if (div_r == DW'(FRAME_DIV - 1)) begin
                        div_s   = '0;
                        frame_s = (frame_r == FW'(4)) ? FW'(5) : FW'(4);
                    end else begin
                        div_s   = div_r + DW'(1);
                    end
                end
                default: begin
                    state_s = ST_FLY;
                    frame_s = FW'(0);
                    div_s   = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Pixel pipeline: address stage, ROM wait stage, palette output stage
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr      <= '0;
            v1_r          <= 1'b0;
            v2_r          <= 1'b0;
            palette_index <= 4'd0;
            sprite_on     <= 1'b0;
        end else begin
            if (in_box_s) begin
                rom_addr <= addr_s;
            end
            v1_r          <= in_box_s;
            v2_r          <= v1_r;
            palette_index <= v2_r ? rom_data : 4'd0;
            sprite_on     <= v2_r && (rom_data != 4'd0);
        end
    end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed self-checking bench for duck_sprite_fetch (expected values adapt when DUCK_SCALE2_EN is defined).
module tb_duck_sprite_fetch;

`ifdef DUCK_SCALE2_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, duck_x, duck_y;
    logic        vs, face_left, shot_hit, respawn;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  palette_index;
    logic        sprite_on;
    logic [1:0]  anim_state;

    int n_checks = 0;
    int n_errors = 0;

    duck_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vs(vs),
        .duck_x(duck_x), .duck_y(duck_y), .face_left(face_left),
        .shot_hit(shot_hit), .respawn(respawn), .rom_addr(rom_addr),
        .rom_data(rom_data), .palette_index(palette_index),
        .sprite_on(sprite_on), .anim_state(anim_state)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One isolated pixel: address one edge later, palette/sprite_on two edges later
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [3:0] rd, input logic [31:0] ea,
                       input logic [31:0] ep, input logic [31:0] eo);
        DrawX = x;
        DrawY = y;
        step();
        check_eq({tag, "_addr"}, 32'(rom_addr), ea);
        DrawX = 10'd0;
        DrawY = 10'd0;
        rom_data = rd;
        step();
        step();
        check_eq({tag, "_pal"}, 32'(palette_index), ep);
        check_eq({tag, "_on"}, 32'(sprite_on), eo);
        rom_data = 4'd0;
    endtask

    task automatic chk_base(input string tag, input logic [31:0] exp);
        DrawX = 10'd100;
        DrawY = 10'd50;
        step();
        check_eq(tag, 32'(rom_addr), exp);
        DrawX = 10'd0;
        DrawY = 10'd0;
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            step();
            step();
            vs = 1'b1;
            step();
        end
    endtask

    initial begin
        Reset = 1'b1; vs = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        duck_x = 10'd100; duck_y = 10'd50; face_left = 1'b0;
        shot_hit = 1'b0; respawn = 1'b0; rom_data = 4'd0;
        step();
        step();
        Reset = 1'b0;
        check_eq("rst_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_pal", 32'(palette_index), 32'd0);
        check_eq("rst_on", 32'(sprite_on), 32'd0);
        check_eq("rst_state", 32'(anim_state), 32'd0);

        pix("topleft", 10'd100, 10'd50, 4'd7, 32'd0, 32'd7, 32'd1);
        pix("botright", 10'd131, 10'd81, 4'd5, SC ? 32'd495 : 32'd1023, 32'd5, 32'd1);
        pix("rightout", 10'd132, 10'd81, 4'd9, SC ? 32'd496 : 32'd1023,
            SC ? 32'd9 : 32'd0, SC ? 32'd1 : 32'd0);
        pix("transp", 10'd110, 10'd60, 4'd0, SC ? 32'd165 : 32'd330, 32'd0, 32'd0);
        face_left = 1'b1;
        pix("mirror", 10'd100, 10'd50, 4'd3, 32'd31, 32'd3, 32'd1);
        face_left = 1'b0;
        duck_x = 10'd620;
        pix("rclip", 10'd639, 10'd50, 4'd2, SC ? 32'd9 : 32'd19, 32'd2, 32'd1);
        pix("nowrap", 10'd0, 10'd51, 4'd6, SC ? 32'd9 : 32'd19, 32'd0, 32'd0);
        duck_y = 10'd460;
        pix("bclip", 10'd639, 10'd479, 4'd8, SC ? 32'd297 : 32'd627, 32'd8, 32'd1);
        duck_x = 10'd100;
        duck_y = 10'd50;
        pix("x63", 10'd163, 10'd50, 4'd4, SC ? 32'd31 : 32'd627,
            SC ? 32'd4 : 32'd0, SC ? 32'd1 : 32'd0);

        chk_base("fly_f0", 32'd0);
        vs_pulses(3);
        chk_base("fly_div3", 32'd0);
        vs_pulses(1);
        chk_base("fly_f1", 32'd1024);
        vs_pulses(4);
        chk_base("fly_f2", 32'd2048);
        vs_pulses(4);
        chk_base("fly_wrap", 32'd0);
        check_eq("fly_state", 32'(anim_state), 32'd0);

        shot_hit = 1'b1;
        step();
        shot_hit = 1'b0;
        check_eq("hit_state", 32'(anim_state), 32'd1);
        chk_base("hit_f3", 32'd3072);
        vs_pulses(29);
        check_eq("hit_hold29", 32'(anim_state), 32'd1);
        vs_pulses(1);
        check_eq("fall_state", 32'(anim_state), 32'd2);
        chk_base("fall_f4", 32'd4096);
        vs_pulses(3);
        chk_base("fall_div3", 32'd4096);
        vs_pulses(1);
        chk_base("fall_f5", 32'd5120);
        vs_pulses(4);
        chk_base("fall_back4", 32'd4096);

        shot_hit = 1'b1;
        step();
        shot_hit = 1'b0;
        check_eq("fall_ignore_hit", 32'(anim_state), 32'd2);

        shot_hit = 1'b1;
        respawn = 1'b1;
        step();
        shot_hit = 1'b0;
        respawn = 1'b0;
        check_eq("respawn_wins", 32'(anim_state), 32'd0);
        chk_base("respawn_f0", 32'd0);

        shot_hit = 1'b1;
        step();
        shot_hit = 1'b0;
        DrawX = 10'd101;
        DrawY = 10'd50;
        rom_data = 4'd4;
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        check_eq("midrst_on", 32'(sprite_on), 32'd0);
        check_eq("midrst_pal", 32'(palette_index), 32'd0);
        check_eq("midrst_state", 32'(anim_state), 32'd0);
        check_eq("midrst_addr", 32'(rom_addr), 32'd0);
        step();
        step();
        check_eq("midrst_flush", 32'(sprite_on), 32'd0);
        rom_data = 4'd0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
